// File: rtl/mem_access_unit.sv
// Data-memory access controller: req/ack bus transaction, lane steering, stall.
// Optional SIGNED_LOAD_EN: lb/lh (opcode[2]=0 loads) sign-extend instead of being illegal.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [5:0]  opcode,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  state_t      state;
  logic [1:0]  size_q;
  logic [1:0]  lane_q;
  logic        sext_q;
  logic [7:0]  cnt;
  logic        start;
  logic        illegal;
  logic        sext_n;
  logic [3:0]  be_n;
  logic [31:0] wd_n;
  logic [31:0] ld;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic        unused_ok;

  assign unused_ok = ^opcode[5:3];
  assign start = mem_read | mem_write;
  assign stall = (state == IDLE && start) || state == REQ;

  always_comb begin
    illegal = mem_read & mem_write;
    case (opcode[1:0])
      2'b10:   illegal = 1'b1;
      2'b01:   if (addr[0]) illegal = 1'b1;
      2'b11:   if (addr[1:0] != 2'b00) illegal = 1'b1;
      default: ;
    endcase
`ifndef SIGNED_LOAD_EN
    if (mem_read && !opcode[2] && opcode[1:0] != 2'b11)
      illegal = 1'b1;
`endif
  end

`ifdef SIGNED_LOAD_EN
  assign sext_n = mem_read & ~opcode[2];
`else
  assign sext_n = 1'b0;
`endif

  always_comb begin
    be_n = 4'b1111;
    wd_n = wdata;
    case (opcode[1:0])
      2'b00: begin
        be_n = 4'b0001 << addr[1:0];
        wd_n = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_n = addr[1] ? 4'b1100 : 4'b0011;
        wd_n = {2{wdata[15:0]}};
      end
      default: ;
    endcase
    if (mem_read) wd_n = 32'h0;
  end

  // Lane extraction uses the size/lane latched at acceptance
  always_comb begin
    ld_b = bus_rdata[8*lane_q +: 8];
    ld_h = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (size_q)
      2'b00:   ld = {{24{sext_q & ld_b[7]}}, ld_b};
      2'b01:   ld = {{16{sext_q & ld_h[15]}}, ld_h};
      default: ld = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rdata     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      cnt       <= '0;
      size_q    <= '0;
      lane_q    <= '0;
      sext_q    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (start && illegal) begin
            state <= ERR;
            err   <= 1'b1;
            rdata <= '0;
          end else if (start) begin
            state     <= REQ;
            size_q    <= opcode[1:0];
            lane_q    <= addr[1:0];
            sext_q    <= sext_n;
            bus_req   <= 1'b1;
            bus_we    <= mem_write;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_be    <= be_n;
            bus_wdata <= wd_n;
          end
        end
        REQ: begin
          if (bus_ack || cnt == TIMEOUT[7:0] - 8'd1) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
          end
          if (bus_ack) begin
            state <= DONE;
            done  <= 1'b1;
            rdata <= ld;
          end else if (cnt == TIMEOUT[7:0] - 8'd1) begin
            state <= ERR;
            err   <= 1'b1;
            rdata <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit.
// Expected values are hand-computed per access.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [5:0]  opcode = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        stall;
  logic        done;
  logic        err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = '0;
  logic        bus_ack = 1'b0;

  int total = 0;
  int bad = 0;
  int n;

  mem_access_unit #(.TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write),
    .opcode(opcode), .addr(addr), .wdata(wdata),
    .rdata(rdata), .stall(stall), .done(done), .err(err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic rd, input logic wr,
                       input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] wd);
    mem_read  = rd;
    mem_write = wr;
    opcode    = op;
    addr      = a;
    wdata     = wd;
  endtask

  task automatic idle_in();
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_req", 32'(bus_req), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    rst = 1'b0;
    cyc();
    chk("idle_done", 32'(done), 32'h0);

    // sw, ack 2 cycles after req
    issue(1'b0, 1'b1, 6'd43, 32'h100, 32'hDEADBEEF);
    #1 chk("sw_stall0", 32'(stall), 32'h1);
    cyc(); idle_in();
    chk("sw_req", 32'(bus_req), 32'h1);
    chk("sw_we", 32'(bus_we), 32'h1);
    chk("sw_addr", bus_addr, 32'h100);
    chk("sw_be", 32'(bus_be), 32'hF);
    chk("sw_wdata", bus_wdata, 32'hDEADBEEF);
    cyc();
    cyc(); bus_ack = 1'b1;
    chk("sw_stall_ack", 32'(stall), 32'h1);
    cyc(); bus_ack = 1'b0;
    chk("sw_done", 32'(done), 32'h1);
    chk("sw_stall_done", 32'(stall), 32'h0);
    chk("sw_req_drop", 32'(bus_req), 32'h0);
    cyc();
    chk("sw_done_pulse", 32'(done), 32'h0);

    // sb to lane 3
    issue(1'b0, 1'b1, 6'd40, 32'h203, 32'h000000A5);
    cyc(); idle_in();
    chk("sb_addr", bus_addr, 32'h200);
    chk("sb_be", 32'(bus_be), 32'h8);
    chk("sb_wdata", bus_wdata, 32'hA5A5A5A5);
    bus_ack = 1'b1;
    cyc(); bus_ack = 1'b0;
    chk("sb_done", 32'(done), 32'h1);
    cyc();

    // lhu upper half
    issue(1'b1, 1'b0, 6'd37, 32'h42, 32'hFFFFFFFF);
    cyc(); idle_in();
    chk("lhu_be", 32'(bus_be), 32'hC);
    chk("lhu_we", 32'(bus_we), 32'h0);
    chk("lhu_wdata", bus_wdata, 32'h0);
    chk("lhu_addr", bus_addr, 32'h40);
    bus_rdata = 32'h8001FFFF; bus_ack = 1'b1;
    cyc(); bus_ack = 1'b0;
    chk("lhu_done", 32'(done), 32'h1);
    chk("lhu_rdata", rdata, 32'h00008001);
    cyc();

    // lh: sign-extends when enabled, otherwise illegal
    issue(1'b1, 1'b0, 6'd33, 32'h42, 32'h0);
`ifdef SIGNED_LOAD_EN
    cyc(); idle_in();
    bus_ack = 1'b1;
    cyc(); bus_ack = 1'b0;
    chk("lh_done", 32'(done), 32'h1);
    chk("lh_rdata", rdata, 32'hFFFF8001);
`else
    cyc(); idle_in();
    chk("lh_err", 32'(err), 32'h1);
    chk("lh_noreq", 32'(bus_req), 32'h0);
`endif
    cyc();

    // lbu lane 1
    issue(1'b1, 1'b0, 6'd36, 32'h1, 32'h0);
    cyc(); idle_in();
    chk("lbu_be", 32'(bus_be), 32'h2);
    bus_rdata = 32'h0000C300; bus_ack = 1'b1;
    cyc(); bus_ack = 1'b0;
    chk("lbu_rdata", rdata, 32'h000000C3);
    cyc();

    // misaligned lw
    issue(1'b1, 1'b0, 6'd35, 32'h6, 32'h0);
    #1 chk("mis_stall0", 32'(stall), 32'h1);
    cyc(); idle_in();
    chk("mis_err", 32'(err), 32'h1);
    chk("mis_noreq", 32'(bus_req), 32'h0);
    chk("mis_stall1", 32'(stall), 32'h0);
    chk("mis_rdata", rdata, 32'h0);
    cyc();
    chk("mis_err_pulse", 32'(err), 32'h0);

    // read and write together
    issue(1'b1, 1'b1, 6'd43, 32'h8, 32'h0);
    cyc(); idle_in();
    chk("rw_err", 32'(err), 32'h1);
    cyc();

    // illegal size 10
    issue(1'b0, 1'b1, 6'd42, 32'h8, 32'h0);
    cyc(); idle_in();
    chk("sz_err", 32'(err), 32'h1);
    cyc();

    // timeout with a late ack
    issue(1'b1, 1'b0, 6'd35, 32'h8, 32'h0);
    cyc(); idle_in();
    n = 0;
    for (int i = 0; i < 40 && bus_req; i++) begin
      n++;
      cyc();
    end
    chk("to_req_cycles", 32'(n), 32'd15);
    chk("to_err", 32'(err), 32'h1);
    chk("to_nodone", 32'(done), 32'h0);
    cyc(); cyc(); cyc();
    bus_ack = 1'b1;
    cyc(); bus_ack = 1'b0;
    chk("late_ack_done", 32'(done), 32'h0);
    chk("late_ack_req", 32'(bus_req), 32'h0);
    cyc();

    // reset mid-REQ, then a normal lw
    issue(1'b1, 1'b0, 6'd35, 32'h10, 32'h0);
    cyc(); idle_in();
    chk("rq_req", 32'(bus_req), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("rq_req_drop", 32'(bus_req), 32'h0);
    chk("rq_stall", 32'(stall), 32'h0);
    #3 rst = 1'b0;
    cyc();
    chk("rq_nodone", 32'(done | err), 32'h0);
    issue(1'b1, 1'b0, 6'd35, 32'h10, 32'h0);
    cyc(); idle_in();
    bus_rdata = 32'h12345678; bus_ack = 1'b1;
    cyc(); bus_ack = 1'b0;
    chk("lw_done", 32'(done), 32'h1);
    chk("lw_rdata", rdata, 32'h12345678);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
